// File: rtl/player_motion.sv
// player_motion: per-frame sprite mover with a four-corner collision probe.
// Define WALL_PHASE_EN to build in the wall-phase power-up timer.
module player_motion #(
    parameter int STEP         = 4,
    parameter int SIZE         = 16,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int START_X      = 40,
    parameter int START_Y      = 30,
    parameter int PHASE_FRAMES = 300
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       collision,
    input  logic       phase_grant,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] BallS,
    output logic       busy,
    output logic       wallPhase_active
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_P0, S_P1, S_P2, S_P3, S_COMMIT
    } state_t;

    localparam logic [7:0]  KEY_W   = 8'h1A;
    localparam logic [7:0]  KEY_S   = 8'h16;
    localparam logic [7:0]  KEY_A   = 8'h04;
    localparam logic [7:0]  KEY_D   = 8'h07;
    localparam logic [9:0]  L_STEP  = 10'(STEP);
    localparam logic [9:0]  L_EDGE  = 10'(SIZE - 1);
    localparam logic [10:0] L_REACH = 11'(STEP + SIZE - 1);
    localparam logic [10:0] L_XMAX  = 11'(X_MAX);
    localparam logic [10:0] L_YMAX  = 11'(Y_MAX);
    localparam logic [9:0]  L_SX    = 10'(START_X);
    localparam logic [9:0]  L_SY    = 10'(START_Y);

    state_t     r_state;
    state_t     w_next;
    logic [9:0] r_ball_x;
    logic [9:0] r_ball_y;
    logic [9:0] r_cx;
    logic [9:0] r_cy;
    logic [9:0] r_probe_x;
    logic [9:0] r_probe_y;
    logic       r_blocked;
    logic [9:0] w_cx;
    logic [9:0] w_cy;
    logic       w_blk;

    assign BallX   = r_ball_x;
    assign BallY   = r_ball_y;
    assign BallS   = 10'(SIZE);
    assign probe_x = r_probe_x;
    assign probe_y = r_probe_y;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state sequencing; a tick arriving while busy is dropped
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (frame_tick) w_next = S_CALC;
            end
            S_CALC:   w_next = S_P0;
            S_P0:     w_next = S_P1;
            S_P1:     w_next = S_P2;
            S_P2:     w_next = S_P3;
            S_P3:     w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default: begin
                busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Candidate position and screen-edge pre-block; 11-bit sums avoid wrap
    always_comb begin
        w_cx  = r_ball_x;
        w_cy  = r_ball_y;
        w_blk = 1'b0;
        case (keycode)
            KEY_W: begin
                w_cy  = r_ball_y - L_STEP;
                w_blk = (r_ball_y < L_STEP);
            end
            KEY_S: begin
                w_cy  = r_ball_y + L_STEP;
                w_blk = ({1'b0, r_ball_y} + L_REACH) > L_YMAX;
            end
            KEY_A: begin
                w_cx  = r_ball_x - L_STEP;
                w_blk = (r_ball_x < L_STEP);
            end
            KEY_D: begin
                w_cx  = r_ball_x + L_STEP;
                w_blk = ({1'b0, r_ball_x} + L_REACH) > L_XMAX;
            end
            default: w_blk = 1'b1;
        endcase
    end

    // Corner walk, sticky block accumulation and move commit
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ball_x  <= L_SX;
            r_ball_y  <= L_SY;
            r_probe_x <= L_SX;
            r_probe_y <= L_SY;
            r_cx      <= L_SX;
            r_cy      <= L_SY;
            r_blocked <= 1'b0;
        end else begin
            case (r_state)
                S_CALC: begin
                    r_cx      <= w_cx;
                    r_cy      <= w_cy;
                    r_blocked <= w_blk;
                    r_probe_x <= w_cx;
                    r_probe_y <= w_cy;
                end
                S_P0: begin
                    r_blocked <= r_blocked | collision;
                    r_probe_x <= r_cx + L_EDGE;
                    r_probe_y <= r_cy;
                end
                S_P1: begin
                    r_blocked <= r_blocked | collision;
                    r_probe_x <= r_cx;
                    r_probe_y <= r_cy + L_EDGE;
                end
                S_P2: begin
                    r_blocked <= r_blocked | collision;
                    r_probe_x <= r_cx + L_EDGE;
                    r_probe_y <= r_cy + L_EDGE;
                end
                S_P3: r_blocked <= r_blocked | collision;
                S_COMMIT: begin
                    r_blocked <= 1'b0;
                    if (!r_blocked) begin
                        r_ball_x  <= r_cx;
                        r_ball_y  <= r_cy;
                        r_probe_x <= r_cx;
                        r_probe_y <= r_cy;
                    end else begin
                        r_probe_x <= r_ball_x;
                        r_probe_y <= r_ball_y;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef WALL_PHASE_EN
    localparam logic [8:0] L_PHASE = 9'(PHASE_FRAMES);

    logic [8:0] r_phase_cnt;
    logic       r_phase_on;
    logic [8:0] w_phase_nxt;

    // Grant reloads (even mid-phase or on a tick); ticks count down
    always_comb begin
        w_phase_nxt = r_phase_cnt;
        if (phase_grant)
            w_phase_nxt = L_PHASE;
        else if (frame_tick && r_phase_cnt != 9'd0)
            w_phase_nxt = r_phase_cnt - 9'd1;
    end

    // Phase counter and registered active flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_phase_cnt <= 9'd0;
            r_phase_on  <= 1'b0;
        end else begin
            r_phase_cnt <= w_phase_nxt;
            r_phase_on  <= (w_phase_nxt != 9'd0);
        end
    end

    assign wallPhase_active = r_phase_on;
`else
    logic w_unused_grant;
    assign w_unused_grant   = phase_grant;
    assign wallPhase_active = 1'b0;
`endif

endmodule

// File: tb/tb_player_motion.sv
// tb_player_motion: scoreboard bench for player_motion.
// Commits are popped and checked by a monitor on each busy fall.
module tb_player_motion;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pos_t;

`ifdef WALL_PHASE_EN
    localparam bit PHASE_EN = 1'b1;
`else
    localparam bit PHASE_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       collision;
    logic       phase_grant = 1'b0;
    logic [9:0] probe_x, probe_y, BallX, BallY, BallS;
    logic       busy, wallPhase_active;

    logic       wall_on = 1'b0;
    logic [9:0] wall_x = 10'd0;
    logic [9:0] wall_y = 10'd0;

    int   n_chk = 0;
    int   n_fail = 0;
    int   mx = 40;
    int   my = 30;
    int   pc = 0;
    pos_t exp_q[$];
    bit   prev_busy = 1'b0;

    player_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .keycode(keycode), .collision(collision),
        .phase_grant(phase_grant), .probe_x(probe_x),
        .probe_y(probe_y), .BallX(BallX), .BallY(BallY),
        .BallS(BallS), .busy(busy),
        .wallPhase_active(wallPhase_active)
    );

    assign collision = wall_on && probe_x == wall_x && probe_y == wall_y;

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Issue one tick with key k; fblk forces an expected collision block,
    // t2 injects a second tick in that cycle, g pulses grant with the tick.
    task automatic move(input logic [7:0] k, input bit fblk = 1'b0,
                        input int t2 = 0, input bit g = 1'b0);
        int nx, ny;
        bit blk;
        nx  = mx;
        ny  = my;
        blk = 1'b0;
        case (k)
            8'h1A: begin ny = my - 4; blk = (my < 4); end
            8'h16: begin ny = my + 4; blk = (my + 19 > 479); end
            8'h04: begin nx = mx - 4; blk = (mx < 4); end
            8'h07: begin nx = mx + 4; blk = (mx + 19 > 639); end
            default: blk = 1'b1;
        endcase
        if (!(blk || fblk)) begin
            mx = nx;
            my = ny;
        end
        exp_q.push_back('{x: 10'(mx), y: 10'(my)});
        if (g) pc = 300;
        else if (pc > 0) pc--;
        keycode     = k;
        frame_tick  = 1'b1;
        phase_grant = g;
        cyc(1);
        frame_tick  = 1'b0;
        phase_grant = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            chk("busy_during_eval", busy, 1);
            if (i == 2) keycode = (k == 8'h1A) ? 8'h16 : 8'h1A;
            frame_tick = (i == t2);
            cyc(1);
        end
        frame_tick = 1'b0;
        chk("busy_after_commit", busy, 0);
    endtask

    // Scoreboard monitor: every completed evaluation must match the queue
    always @(negedge Clk) begin
        pos_t e;
        if (Reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_commit", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("commit_x", BallX, e.x);
                    chk("commit_y", BallY, e.y);
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(2);
        chk("rst_x", BallX, 40);
        chk("rst_y", BallY, 30);
        chk("rst_busy", busy, 0);
        chk("rst_px", probe_x, 40);
        chk("rst_py", probe_y, 30);
        chk("rst_size", BallS, 16);
        chk("rst_phase", wallPhase_active, 0);
        Reset = 1'b0;
        cyc(1);

        wall_on = 1'b1;
        wall_x  = 10'd59;
        wall_y  = 10'd30;
        move(8'h07, 1'b1);
        wall_on = 1'b0;
        chk("wall_hold_x", BallX, 40);

        move(8'h07);
        chk("free_move_x", BallX, 44);
        move(8'h00);
        move(8'h55);

        move(8'h1A, 1'b0, 3);
        for (int i = 0; i < 4; i++) begin
            chk("dropped_tick_idle", busy, 0);
            cyc(1);
        end
        chk("up_once_y", BallY, 26);

        for (int i = 0; i < 12; i++) move(8'h04);
        chk("left_edge_x", BallX, 0);
        for (int i = 0; i < 7; i++) move(8'h1A);
        chk("top_edge_y", BallY, 2);
        for (int i = 0; i < 157; i++) move(8'h07);
        chk("right_edge_x", BallX, 624);
        for (int i = 0; i < 116; i++) move(8'h16);
        chk("bottom_edge_y", BallY, 462);

        keycode    = 8'h04;
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(3);
        Reset = 1'b1;
        cyc(1);
        chk("midrst_x", BallX, 40);
        chk("midrst_y", BallY, 30);
        chk("midrst_busy", busy, 0);
        cyc(1);
        Reset = 1'b0;
        mx = 40;
        my = 30;
        move(8'h07);
        chk("post_rst_move_x", BallX, 44);

        phase_grant = 1'b1;
        pc = 300;
        cyc(1);
        phase_grant = 1'b0;
        chk("phase_grant", wallPhase_active, PHASE_EN);
        for (int n = 1; n <= 450; n++) begin
            move(8'h00, 1'b0, 0, n == 150);
            chk("phase_tick", wallPhase_active, PHASE_EN && pc != 0);
        end
        chk("phase_end", wallPhase_active, 0);

        cyc(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
